// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared game-state layout, field widths and fetch FSM encoding
package pong_pkg;

  localparam logic [2:0] OFF_BALL_X  = 3'd0;
  localparam logic [2:0] OFF_BALL_Y  = 3'd1;
  localparam logic [2:0] OFF_PAD_L_Y = 3'd2;
  localparam logic [2:0] OFF_PAD_R_Y = 3'd3;
  localparam logic [2:0] OFF_SCORE_L = 3'd4;
  localparam logic [2:0] OFF_SCORE_R = 3'd5;

  localparam int POS_W   = 10;
  localparam int SCORE_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/frame_snapshot.sv
// rtl/frame_snapshot.sv - per-frame fetch of the six-word game-state block with atomic commit
module frame_snapshot
  import pong_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd32,
  parameter int          NUM_WORDS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  output logic [31:0]        roa,
  input  logic [31:0]        rod,
  output logic [POS_W-1:0]   ball_x,
  output logic [POS_W-1:0]   ball_y,
  output logic [POS_W-1:0]   pad_l_y,
  output logic [POS_W-1:0]   pad_r_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic       capture;
  logic       commit;

  logic [POS_W-1:0]   stg_ball_x, stg_ball_y, stg_pad_l_y, stg_pad_r_y;
  logic [SCORE_W-1:0] stg_score_l, stg_score_r;

  // Whole 32-bit word is compared so stray high bits also saturate the score.
  function automatic logic [SCORE_W-1:0] sat_score(input logic [31:0] word);
    if (word > 32'(SCORE_MAX)) begin
      return SCORE_MAX;
    end
    return word[SCORE_W-1:0];
  endfunction

  always_comb begin
    state_n = state;
    idx_n   = idx;
    capture = 1'b0;
    commit  = 1'b0;
    roa     = BASE_ADDR;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_n = ST_FETCH;
          idx_n   = 3'd0;
        end
      end
      ST_FETCH: begin
        roa     = BASE_ADDR + 32'(idx);
        capture = 1'b1;
        idx_n   = idx + 3'd1;
        if (idx == LAST_IDX) begin
          state_n = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      busy  <= (state_n != ST_IDLE);
      done  <= commit;
      // A pulse landing on the commit cycle is also an overrun: it is never queued.
      if (frame_start && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_ball_x  <= '0;
      stg_ball_y  <= '0;
      stg_pad_l_y <= '0;
      stg_pad_r_y <= '0;
      stg_score_l <= '0;
      stg_score_r <= '0;
    end else if (capture) begin
      case (idx)
        OFF_BALL_X:  stg_ball_x  <= rod[POS_W-1:0];
        OFF_BALL_Y:  stg_ball_y  <= rod[POS_W-1:0];
        OFF_PAD_L_Y: stg_pad_l_y <= rod[POS_W-1:0];
        OFF_PAD_R_Y: stg_pad_r_y <= rod[POS_W-1:0];
        OFF_SCORE_L: stg_score_l <= sat_score(rod);
        OFF_SCORE_R: stg_score_r <= sat_score(rod);
        default: ;
      endcase
    end
  end

  // The renderer only ever sees a full set: all six outputs load on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_x  <= '0;
      ball_y  <= '0;
      pad_l_y <= '0;
      pad_r_y <= '0;
      score_l <= '0;
      score_r <= '0;
    end else if (commit) begin
      ball_x  <= stg_ball_x;
      ball_y  <= stg_ball_y;
      pad_l_y <= stg_pad_l_y;
      pad_r_y <= stg_pad_r_y;
      score_l <= stg_score_l;
      score_r <= stg_score_r;
    end
  end

endmodule

// File: tb/tb_frame_snapshot.sv
// tb/tb_frame_snapshot.sv - directed vector bench for frame_snapshot
module tb_frame_snapshot;

  typedef struct {
    logic [5:0][31:0] w;
    logic [9:0] bx, by, pl, pr;
    logic [3:0] sl, sr;
  } vec_t;

  logic clk, rst;
  logic fs_a, fs_b;
  logic [31:0] roa_a, rod_a, roa_b, rod_b;
  logic [9:0] bx_a, by_a, pl_a, pr_a, bx_b, by_b, pl_b, pr_b;
  logic [3:0] sl_a, sr_a, sl_b, sr_b;
  logic busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;

  logic [31:0] mem [64];
  int errors = 0;
  int checks = 0;
  vec_t vecs [4];

  // Memory capacity is 64 words; addresses beyond read as zero.
  assign rod_a = (roa_a < 32'd64) ? mem[roa_a[5:0]] : 32'd0;
  assign rod_b = (roa_b < 32'd64) ? mem[roa_b[5:0]] : 32'd0;

  frame_snapshot #(.BASE_ADDR(32'd32), .NUM_WORDS(6)) dut_a (
    .clk(clk), .rst(rst), .frame_start(fs_a), .roa(roa_a), .rod(rod_a),
    .ball_x(bx_a), .ball_y(by_a), .pad_l_y(pl_a), .pad_r_y(pr_a),
    .score_l(sl_a), .score_r(sr_a), .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  frame_snapshot #(.BASE_ADDR(32'd60), .NUM_WORDS(6)) dut_b (
    .clk(clk), .rst(rst), .frame_start(fs_b), .roa(roa_b), .rod(rod_b),
    .ball_x(bx_b), .ball_y(by_b), .pad_l_y(pl_b), .pad_r_y(pr_b),
    .score_l(sl_b), .score_r(sr_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mkvec(input logic [31:0] w0, w1, w2, w3, w4, w5,
                                 input logic [9:0] bx, by, pl, pr, input logic [3:0] sl, sr);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
    v.bx = bx; v.by = by; v.pl = pl; v.pr = pr; v.sl = sl; v.sr = sr;
    return v;
  endfunction

  // k counts negedges after the pulse; done after edge 7 is seen at k == 8.
  task automatic run_frame(input int wr_at, input logic [5:0] wr_addr, input logic [31:0] wr_data,
                           input int fs_at, input int rst_at, output int n_done, output int first_done);
    n_done = 0;
    first_done = 0;
    @(negedge clk);
    fs_a = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      fs_a = 1'b0;
      if (done_a) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
      if (rst_at == 0 && k <= 6) chk($sformatf("roa_k%0d", k), roa_a, 32'(32 + k - 1));
      if (rst_at == 0 && k == 1) chk("busy_fetch", {31'd0, busy_a}, 32'd1);
      if (rst_at != 0 && k == rst_at + 1) begin
        chk("rst_ball_x", {22'd0, bx_a}, 32'd0);
        chk("rst_score_r", {28'd0, sr_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
      end
      if (k == wr_at) mem[wr_addr] = wr_data;
      if (k == fs_at) fs_a = 1'b1;
      if (k == rst_at) rst = 1'b1;
    end
  endtask

  task automatic chk_outs(input string tag, input logic [9:0] bx, by, pl, pr, input logic [3:0] sl, sr);
    chk({tag, "_ball_x"}, {22'd0, bx_a}, {22'd0, bx});
    chk({tag, "_ball_y"}, {22'd0, by_a}, {22'd0, by});
    chk({tag, "_pad_l_y"}, {22'd0, pl_a}, {22'd0, pl});
    chk({tag, "_pad_r_y"}, {22'd0, pr_a}, {22'd0, pr});
    chk({tag, "_score_l"}, {28'd0, sl_a}, {28'd0, sl});
    chk({tag, "_score_r"}, {28'd0, sr_a}, {28'd0, sr});
  endtask

  initial begin
    int nd, fd, nb;
    vecs[0] = mkvec(100, 200, 50, 60, 3, 7, 100, 200, 50, 60, 3, 7);
    vecs[1] = mkvec(32'h0000_0401, 5, 6, 7, 12, 32'hFFFF_FFFF, 1, 5, 6, 7, 9, 9);
    vecs[2] = mkvec(1023, 1024, 32'h12345, 0, 9, 10, 1023, 0, 10'h345, 0, 9, 9);
    vecs[3] = mkvec(0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 8);

    rst = 1'b1;
    fs_a = 1'b0;
    fs_b = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    chk("reset_done", {31'd0, done_a}, 32'd0);
    chk("reset_overrun", {31'd0, ovr_a}, 32'd0);
    chk("reset_roa_a", roa_a, 32'd32);
    chk("reset_roa_b", roa_b, 32'd60);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 6; j++) mem[32 + j] = vecs[i].w[j];
      run_frame(0, 6'd0, 32'd0, 0, 0, nd, fd);
      chk($sformatf("v%0d_done_count", i), 32'(nd), 32'd1);
      chk($sformatf("v%0d_latency", i), 32'(fd), 32'd8);
      chk_outs($sformatf("v%0d", i), vecs[i].bx, vecs[i].by, vecs[i].pl, vecs[i].pr, vecs[i].sl, vecs[i].sr);
      chk($sformatf("v%0d_busy_idle", i), {31'd0, busy_a}, 32'd0);
    end

    // CPU rewrites word 1 after it was captured: this frame keeps the old value.
    mem[32] = 100; mem[33] = 200; mem[34] = 50; mem[35] = 60; mem[36] = 3; mem[37] = 7;
    run_frame(3, 6'd33, 32'd300, 0, 0, nd, fd);
    chk("midwr_done_count", 32'(nd), 32'd1);
    chk("midwr_ball_y_old", {22'd0, by_a}, 32'd200);
    run_frame(0, 6'd0, 32'd0, 0, 0, nd, fd);
    chk_outs("midwr_next", 100, 300, 50, 60, 3, 7);

    // Second pulse during fetch is ignored and latches overrun.
    chk("pre_overrun", {31'd0, ovr_a}, 32'd0);
    run_frame(0, 6'd0, 32'd0, 4, 0, nd, fd);
    chk("ovr_done_count", 32'(nd), 32'd1);
    chk("ovr_latency", 32'(fd), 32'd8);
    chk("ovr_flag", {31'd0, ovr_a}, 32'd1);
    run_frame(0, 6'd0, 32'd0, 0, 0, nd, fd);
    chk("ovr_next_done_count", 32'(nd), 32'd1);
    chk("ovr_sticky", {31'd0, ovr_a}, 32'd1);

    // Pulse landing exactly on the commit cycle (k=7 drives it into edge 7).
    run_frame(0, 6'd0, 32'd0, 7, 0, nd, fd);
    chk("cmt_pulse_done_count", 32'(nd), 32'd1);

    // Asynchronous reset mid-fetch aborts without a done pulse.
    run_frame(0, 6'd0, 32'd0, 0, 4, nd, fd);
    chk("rst_done_count", 32'(nd), 32'd0);
    chk("rst_overrun_clear", {31'd0, ovr_a}, 32'd0);
    chk_outs("rst_after", 0, 0, 0, 0, 0, 0);
    run_frame(0, 6'd0, 32'd0, 0, 0, nd, fd);
    chk("rst_next_done_count", 32'(nd), 32'd1);
    chk_outs("rst_next", 100, 300, 50, 60, 3, 7);

    // Base near the top of memory: words 4 and 5 fall off the end and read 0.
    mem[60] = 11; mem[61] = 22; mem[62] = 33; mem[63] = 44;
    nb = 0;
    @(negedge clk);
    fs_b = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      fs_b = 1'b0;
      if (done_b) nb++;
      if (k == 5) chk("b_roa_k5", roa_b, 32'd64);
    end
    chk("b_done_count", 32'(nb), 32'd1);
    chk("b_ball_x", {22'd0, bx_b}, 32'd11);
    chk("b_ball_y", {22'd0, by_b}, 32'd22);
    chk("b_pad_l_y", {22'd0, pl_b}, 32'd33);
    chk("b_pad_r_y", {22'd0, pr_b}, 32'd44);
    chk("b_score_l", {28'd0, sl_b}, 32'd0);
    chk("b_score_r", {28'd0, sr_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
